// File: rtl/hilo_muldiv.sv
// HI/LO write-side mul/div unit: 1-cycle MULT/MULTU, 32-step restoring DIV/DIVU.
// Latency: multiply result in cycle 1; divide in cycle 33 (cycle 1 on early exit when MULDIV_EARLY_EXIT_EN is defined).
// Backpressure: stall_o holds the pipeline while a divide runs; start is only sampled in IDLE.
module hilo_muldiv #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        stall_o,
    output logic        hilo_we,
    output logic [63:0] hilo_o
);

    typedef enum logic [1:0] {IDLE, MUL_DONE, DIV_RUN, DIV_DONE} state_t;

    localparam logic [4:0] LAST_STEP = 5'(DIV_CYCLES - 1);

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvs;
    logic        neg_q;
    logic        neg_r;
    logic        dz;
    logic [63:0] res;
    logic [63:0] hilo_last;

    logic        accept;
    logic        is_signed;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic        early;

    logic [31:0] rem_sh;
    logic        ge;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign accept    = (state == IDLE) && start && !flush;
    assign is_signed = ~op[0];

    // Sign-extending both operands to 64 bits lets one unsigned multiplier serve MULT and MULTU.
    assign ext_a = {{32{is_signed & src_a[31]}}, src_a};
    assign ext_b = {{32{is_signed & src_b[31]}}, src_b};
    assign prod  = ext_a * ext_b;

    assign neg_a = is_signed & src_a[31];
    assign neg_b = is_signed & src_b[31];
    assign mag_a = neg_a ? -src_a : src_a;
    assign mag_b = neg_b ? -src_b : src_b;

`ifdef MULDIV_EARLY_EXIT_EN
    assign early = (src_b == 32'h0) || (mag_a < mag_b);
`else
    assign early = 1'b0;
`endif

    // One restoring step; the shifted-out remainder MSB forces a subtract since the true value exceeds dvs.
    assign rem_sh  = {rem[30:0], quo[31]};
    assign ge      = rem[31] || (rem_sh >= dvs);
    assign rem_nxt = ge ? (rem_sh - dvs) : rem_sh;
    assign quo_nxt = {quo[30:0], ge};
    assign q_fix   = neg_q ? -quo_nxt : quo_nxt;
    assign r_fix   = neg_r ? -rem_nxt : rem_nxt;

    assign stall_o = (state == DIV_RUN) || ((state == IDLE) && start && op[1] && !flush);
    assign hilo_we = ((state == MUL_DONE) || (state == DIV_DONE)) && !flush && !rst;
    assign hilo_o  = hilo_we ? res : hilo_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            hilo_last <= 64'h0;
        end else begin
            if (hilo_we) begin
                hilo_last <= res;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!op[1]) begin
                            res   <= prod;
                            state <= MUL_DONE;
                        end else begin
                            quo   <= mag_a;
                            rem   <= 32'h0;
                            dvs   <= mag_b;
                            neg_q <= neg_a ^ neg_b;
                            neg_r <= neg_a;
                            dz    <= (src_b == 32'h0);
                            cnt   <= 5'd0;
                            if (src_b == 32'h0) begin
                                res <= {src_a, 32'hFFFF_FFFF};
                            end else if (early) begin
                                res <= {src_a, 32'h0};
                            end
                            state <= early ? DIV_DONE : DIV_RUN;
                        end
                    end
                end
                DIV_RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        quo <= quo_nxt;
                        rem <= rem_nxt;
                        cnt <= cnt + 5'd1;
                        if (cnt == LAST_STEP) begin
                            state <= DIV_DONE;
                            if (!dz) begin
                                res <= {r_fix, q_fix};
                            end
                        end
                    end
                end
                MUL_DONE, DIV_DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: vector table of complete operations plus flush/reset/back-to-back sequences.
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = 32'h0;
    logic [31:0] src_b = 32'h0;
    logic        stall_o;
    logic        hilo_we;
    logic [63:0] hilo_o;

    int total = 0;
    int bad = 0;

`ifdef MULDIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    hilo_muldiv dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .stall_o (stall_o),
        .hilo_we (hilo_we),
        .hilo_o  (hilo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        early;
        logic [63:0] exp;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1ns later, well before the next rising edge.
    task automatic drive(input logic s, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic f, input logic r);
        @(negedge clk);
        start = s;
        op    = o;
        src_a = a;
        src_b = b;
        flush = f;
        rst   = r;
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 2'($urandom), $urandom, $urandom, 1'b0, 1'b0);
    endtask

    initial begin
        logic [63:0] prev;
        int          lat;
        int          exp_lat;
        logic        got;
        logic        we_seen;
        logic        stall_seen;

        vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 64'h0000_0001_FFFF_FFFE};
        vecs[2]  = '{2'b00, 32'h0000_0003, 32'h0000_0004, 1'b0, 64'h0000_0000_0000_000C};
        vecs[3]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
        vecs[4]  = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[5]  = '{2'b11, 32'd100,       32'd7,         1'b0, 64'h0000_0002_0000_000E};
        vecs[6]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[7]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_8000_0000};
        vecs[8]  = '{2'b11, 32'h0000_0005, 32'h0000_0000, 1'b1, 64'h0000_0005_FFFF_FFFF};
        vecs[9]  = '{2'b11, 32'h0000_0003, 32'h0000_0009, 1'b1, 64'h0000_0003_0000_0000};
        vecs[10] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 64'h0000_0001_FFFF_FFFD};
        vecs[11] = '{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 1'b1, 64'hFFFF_FFFB_FFFF_FFFF};
        vecs[12] = '{2'b10, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFD_0000_0000};
        vecs[13] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'h0000_0000_FFFF_FFFF};
        vecs[14] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 64'h0000_000F_0FFF_FFFF};

        repeat (3) drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 2'b10, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("reset_we", 64'(hilo_we), 64'h0);
        chk("reset_hilo", hilo_o, 64'h0);
        chk("reset_stall", 64'(stall_o), 64'h0);

        // Each vector starts in the cycle right after the previous result (back-to-back acceptance).
        prev = 64'h0;
        for (int i = 0; i < NV; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0);
            chk($sformatf("v%0d_stall_c0", i), 64'(stall_o), 64'(vecs[i].op[1]));
            chk($sformatf("v%0d_we_c0", i), 64'(hilo_we), 64'h0);
            chk($sformatf("v%0d_hold_c0", i), hilo_o, prev);
            exp_lat = (!vecs[i].op[1] || (EARLY && vecs[i].early)) ? 1 : 33;
            lat = 0;
            got = 1'b0;
            while (!got && lat < 40) begin
                idle_cycle();
                lat++;
                chk($sformatf("v%0d_stall_c%0d", i, lat), 64'(stall_o),
                    64'(vecs[i].op[1] && (lat < exp_lat)));
                got = hilo_we;
            end
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(exp_lat));
            chk($sformatf("v%0d_result", i), hilo_o, vecs[i].exp);
            prev = vecs[i].exp;
        end

        // Start asserted in the DONE cycle must be dropped.
        drive(1'b1, 2'b00, 32'd5, 32'd5, 1'b0, 1'b0);
        drive(1'b1, 2'b00, 32'd2, 32'd2, 1'b0, 1'b0);
        chk("done_start_we", 64'(hilo_we), 64'h1);
        chk("done_start_val", hilo_o, 64'h19);
        idle_cycle();
        chk("done_start_ignored_we", 64'(hilo_we), 64'h0);
        chk("done_start_hold", hilo_o, 64'h19);

        // Flush coinciding with MUL_DONE suppresses the write.
        drive(1'b1, 2'b00, 32'd2, 32'd3, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("mulflush_we", 64'(hilo_we), 64'h0);
        chk("mulflush_hold", hilo_o, 64'h19);
        idle_cycle();
        chk("mulflush_after_we", 64'(hilo_we), 64'h0);

        // Start together with flush in IDLE is not accepted.
        drive(1'b1, 2'b10, 32'd100, 32'd7, 1'b1, 1'b0);
        chk("startflush_stall", 64'(stall_o), 64'h0);
        idle_cycle();
        chk("startflush_noaccept", 64'(stall_o), 64'h0);

        // Divide flushed at cycle 10, then MULT 3*4 in cycle 11.
        drive(1'b1, 2'b10, 32'd100, 32'd7, 1'b0, 1'b0);
        chk("divflush_stall_c0", 64'(stall_o), 64'h1);
        we_seen = 1'b0;
        for (int c = 1; c < 10; c++) begin
            idle_cycle();
            we_seen |= hilo_we;
        end
        drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("divflush_stall_c10", 64'(stall_o), 64'h1);
        we_seen |= hilo_we;
        drive(1'b1, 2'b00, 32'd3, 32'd4, 1'b0, 1'b0);
        chk("divflush_stall_c11", 64'(stall_o), 64'h0);
        we_seen |= hilo_we;
        chk("divflush_no_we_c1_11", 64'(we_seen), 64'h0);
        idle_cycle();
        chk("divflush_mul_we_c12", 64'(hilo_we), 64'h1);
        chk("divflush_mul_val_c12", hilo_o, 64'hC);
        we_seen = 1'b0;
        stall_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            idle_cycle();
            we_seen |= hilo_we;
            stall_seen |= stall_o;
        end
        chk("divflush_no_late_we", 64'(we_seen), 64'h0);
        chk("divflush_no_late_stall", 64'(stall_seen), 64'h0);

        // Reset at cycle 20 of a divide, with a start offered during reset.
        drive(1'b1, 2'b10, 32'd100, 32'd7, 1'b0, 1'b0);
        for (int c = 1; c < 20; c++) idle_cycle();
        drive(1'b1, 2'b00, 32'd3, 32'd3, 1'b0, 1'b1);
        drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("rst_mid_hilo_c21", hilo_o, 64'h0);
        chk("rst_mid_we_c21", 64'(hilo_we), 64'h0);
        chk("rst_mid_stall_c21", 64'(stall_o), 64'h0);
        we_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            idle_cycle();
            we_seen |= hilo_we;
        end
        chk("rst_mid_no_we", 64'(we_seen), 64'h0);
        chk("rst_mid_hilo_hold", hilo_o, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
